// File: rtl/trace_capture_pkg.sv
// Shared types, mode encodings and width helpers for the trace capture buffer.
package trace_capture_pkg;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_CHANNELS = 2;

    function automatic int chIdW(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int entryW(input int dataW, input int channels);
        return chIdW(channels) + dataW;
    endfunction

    typedef struct packed {
        logic [chIdW(DEF_CHANNELS)-1:0] ch;
        logic [DEF_DATA_W-1:0]          data;
    } tc_entry_t;

endpackage

// File: rtl/trace_capture_if.sv
// Source strobes and reader drain handshake of the trace capture buffer.
interface trace_capture_if
    import trace_capture_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int CHANNELS = 2
);

    localparam int CH_W = chIdW(CHANNELS);

    logic [CHANNELS-1:0]        ch_valid;
    logic [CHANNELS*DATA_W-1:0] ch_data;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_ch;
    logic                       out_ready;

    modport master (
        output ch_valid, ch_data, out_ready,
        input  out_valid, out_data, out_ch
    );

    modport slave (
        input  ch_valid, ch_data, out_ready,
        output out_valid, out_data, out_ch
    );

endinterface

// File: rtl/tc_fifo.sv
// Pointer-based first-word-fall-through FIFO with optional overwrite of the
// oldest entry when pushing into a full buffer.
module tc_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       force_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             isFull, isEmpty, doPush, doPop, overwrite;

    // A full push without a pop only proceeds when overwrite is forced; it
    // then advances both pointers so the oldest entry falls off.
    always_comb begin
        isFull    = (level_q == LW'(DEPTH));
        isEmpty   = (level_q == '0);
        doPop     = pop_i && !isEmpty;
        doPush    = push_i && (!isFull || doPop || force_i);
        overwrite = doPush && isFull && !doPop;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop || overwrite) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop && !overwrite) begin
            level_d = level_q + 1'b1;
        end else if (doPop && !doPush) begin
            level_d = level_q - 1'b1;
        end
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear_i) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = isEmpty ? '0 : mem[rdPtr_q];
    assign level_o = level_q;
    assign full_o  = isFull;
    assign empty_o = isEmpty;

endmodule

// File: rtl/trace_capture.sv
// Multi-channel capture buffer: per-channel hold registers, a round-robin
// arbiter into a shared tagged FIFO, and saturating per-channel loss counters.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    trace_capture_if.slave             bus,
    input  logic                       clear_i,
    input  logic                       cap_en_i,
    input  logic                       wrap_mode_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o,
    output logic [CHANNELS*CNT_W-1:0]  drop_cnt_o
);

    localparam int CH_W    = chIdW(CHANNELS);
    localparam int ENTRY_W = entryW(DATA_W, CHANNELS);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CHANNELS-1:0] holdV_q, holdV_d;
    logic [DATA_W-1:0]   holdD_q [CHANNELS];
    logic [DATA_W-1:0]   holdD_d [CHANNELS];
    logic [CNT_W-1:0]    dropCnt_q [CHANNELS];
    logic [CNT_W-1:0]    dropCnt_d [CHANNELS];
    logic [CH_W-1:0]     lastGrant_q, lastGrant_d;
    logic                ovf_q, ovf_d;

    logic                fifoFull, fifoEmpty, pop, permit, wrapMode;
    logic                grantValid;
    logic [CH_W-1:0]     grantIdx, cand;
    int                  idx;
    entry_t              pushEntry, headEntry;

    assign wrapMode = (wrap_mode_i == MODE_WRAP);
    assign pop      = !fifoEmpty && bus.out_ready;
    assign permit   = wrapMode || !fifoFull || pop;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        cand       = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = int'(lastGrant_q) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            cand = CH_W'(idx);
            if (!grantValid && permit && !clear_i && holdV_q[cand]) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    // A granted hold may reload in the same cycle; only a busy, ungranted
    // hold turns a new arrival into a counted drop.
    always_comb begin
        holdV_d     = holdV_q;
        holdD_d     = holdD_q;
        dropCnt_d   = dropCnt_q;
        lastGrant_d = grantValid ? grantIdx : lastGrant_q;
        ovf_d       = ovf_q || (grantValid && fifoFull && !pop && wrapMode);
        for (int c = 0; c < CHANNELS; c++) begin
            if (grantValid && (grantIdx == CH_W'(c))) begin
                holdV_d[c] = 1'b0;
            end
            if (bus.ch_valid[c] && cap_en_i) begin
                if (holdV_q[c] && !(grantValid && (grantIdx == CH_W'(c)))) begin
                    if (dropCnt_q[c] != '1) begin
                        dropCnt_d[c] = dropCnt_q[c] + 1'b1;
                    end
                end else begin
                    holdV_d[c] = 1'b1;
                    holdD_d[c] = bus.ch_data[c*DATA_W +: DATA_W];
                end
            end
        end
        if (clear_i) begin
            holdV_d     = '0;
            lastGrant_d = CH_W'(CHANNELS-1);
            ovf_d       = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                dropCnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdV_q     <= '0;
            lastGrant_q <= CH_W'(CHANNELS-1);
            ovf_q       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                holdD_q[c]   <= '0;
                dropCnt_q[c] <= '0;
            end
        end else begin
            holdV_q     <= holdV_d;
            holdD_q     <= holdD_d;
            dropCnt_q   <= dropCnt_d;
            lastGrant_q <= lastGrant_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        pushEntry.ch   = grantIdx;
        pushEntry.data = holdD_q[grantIdx];
    end

    tc_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (grantValid),
        .pop_i   (pop),
        .force_i (wrapMode),
        .wdata_i (pushEntry),
        .rdata_o (headEntry),
        .level_o (level_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign bus.out_valid = !fifoEmpty;
    assign bus.out_data  = headEntry.data;
    assign bus.out_ch    = headEntry.ch;
    assign full_o        = fifoFull;
    assign empty_o       = fifoEmpty;
    assign ovf_o         = ovf_q;

    always_comb begin
        drop_cnt_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            drop_cnt_o[c*CNT_W +: CNT_W] = dropCnt_q[c];
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: expected words are queued as stimulus is
// driven and retired by a monitor whenever the reader accepts the head.
module tb_trace_capture;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 16;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       clear;
    logic                       capEn;
    logic                       wrapMode;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       full, empty, ovf;
    logic [CHANNELS*CNT_W-1:0]  dropCnt;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] expQ [$];
    logic [DATA_W:0] expWord;

    trace_capture_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

    trace_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_i     (clear),
        .cap_en_i    (capEn),
        .wrap_mode_i (wrapMode),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty),
        .ovf_o       (ovf),
        .drop_cnt_o  (dropCnt)
    );

    always #5 clk = ~clk;

    // Retire one queued expectation for every accepted head word.
    always @(negedge clk) begin
        if (rst && !clear && bus.out_valid && bus.out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_extra got ch=%0d data=%0h required no word", bus.out_ch, bus.out_data);
            end else begin
                expWord = expQ.pop_front();
                if ({bus.out_ch, bus.out_data} !== expWord) begin
                    errors++;
                    $display("[TB] FAIL sb_word got ch=%0d data=%0h required ch=%0d data=%0h",
                             bus.out_ch, bus.out_data, expWord[DATA_W], expWord[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1);
        bus.ch_valid = v;
        bus.ch_data  = {d1, d0};
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expQ.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_ch} !== 66'd0) begin
            errors++;
            $display("[TB] FAIL reset_out got v=%0b d=%0h ch=%0d required 0", bus.out_valid, bus.out_data, bus.out_ch);
        end
        checks++;
        if ({level, full, empty, ovf, dropCnt} !== {5'd0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_status got lvl=%0d f=%0b e=%0b o=%0b drop=%0h required 0/0/1/0/0",
                     level, full, empty, ovf, dropCnt);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wrapMode = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'b01, 64'h60, 64'h0);
        expQ.push_back({1'b0, 64'h60});
        tick();
        drive(2'b00, 64'h0, 64'h0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency got out_valid=%0b required 0", bus.out_valid);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_ch, level} !== {1'b1, 64'h60, 1'b0, 5'd1}) begin
            errors++;
            $display("[TB] FAIL single_head got v=%0b d=%0h ch=%0d lvl=%0d required 1/60/0/1",
                     bus.out_valid, bus.out_data, bus.out_ch, level);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_empty got %0b required 1", empty);
        end
    endtask

    task automatic test_round_robin();
        doClear();
        bus.out_ready = 1'b1;
        expQ.push_back({1'b0, 64'hA00});
        expQ.push_back({1'b1, 64'hB00});
        expQ.push_back({1'b0, 64'hA01});
        expQ.push_back({1'b1, 64'hB02});
        expQ.push_back({1'b0, 64'hA03});
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 64'hA00 + 64'(k), 64'hB00 + 64'(k));
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_drain got %0d words left required 0", expQ.size());
        end
        checks++;
        if (dropCnt !== {16'd2, 16'd1}) begin
            errors++;
            $display("[TB] FAIL rr_drops got %0h required 00020001", dropCnt);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stop_full();
        doClear();
        wrapMode = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(2'b01, 64'(k), 64'h0);
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        tick();
        checks++;
        if ({level, full, ovf, bus.out_data} !== {5'd16, 1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("[TB] FAIL stop_full got lvl=%0d f=%0b o=%0b head=%0h required 16/1/0/0", level, full, ovf, bus.out_data);
        end
        checks++;
        if (dropCnt !== {16'd0, 16'd3}) begin
            errors++;
            $display("[TB] FAIL stop_drops got %0h required 00000003", dropCnt);
        end
        for (int k = 0; k <= 16; k++) expQ.push_back({1'b0, 64'(k)});
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0 || level !== 5'd0) begin
            errors++;
            $display("[TB] FAIL stop_drain got %0d left lvl=%0d required 0/0", expQ.size(), level);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap_full();
        doClear();
        wrapMode = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(2'b01, 64'(k), 64'h0);
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        tick();
        checks++;
        if ({level, ovf, bus.out_data, dropCnt} !== {5'd16, 1'b1, 64'd4, 32'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_full got lvl=%0d o=%0b head=%0h drop=%0h required 16/1/4/0",
                     level, ovf, bus.out_data, dropCnt);
        end
        for (int k = 4; k < 20; k++) expQ.push_back({1'b0, 64'(k)});
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL wrap_drain got %0d words left required 0", expQ.size());
        end
        bus.out_ready = 1'b0;
        wrapMode = 1'b0;
    endtask

    task automatic test_push_pop_full();
        doClear();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(2'b01, 64'h100 + 64'(k), 64'h0);
            expQ.push_back({1'b0, 64'h100 + 64'(k)});
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        tick();
        drive(2'b01, 64'h200, 64'h0);
        expQ.push_back({1'b0, 64'h200});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        drive(2'b00, 64'h0, 64'h0);
        checks++;
        if ({level, ovf, dropCnt} !== {5'd16, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL pushpop_full got lvl=%0d o=%0b drop=%0h required 16/0/0", level, ovf, dropCnt);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pushpop_drain got %0d words left required 0", expQ.size());
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        doClear();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(2'b01, 64'h300 + 64'(k), 64'h0);
            expQ.push_back({1'b0, 64'h300 + 64'(k)});
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0 || dropCnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b2b got %0d left drop=%0h required 0/0", expQ.size(), dropCnt);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_clear();
        wrapMode = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(2'b11, 64'hD00 + 64'(k), 64'hE00 + 64'(k));
            tick();
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_pre_ovf got %0b required 1", ovf);
        end
        doClear();
        drive(2'b00, 64'h0, 64'h0);
        checks++;
        if ({level, ovf, dropCnt, bus.out_valid} !== {5'd0, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_state got lvl=%0d o=%0b drop=%0h v=%0b required 0/0/0/0",
                     level, ovf, dropCnt, bus.out_valid);
        end
        tick();
        tick();
        checks++;
        if (level !== 5'd0) begin
            errors++;
            $display("[TB] FAIL clear_holds got lvl=%0d required 0", level);
        end
        drive(2'b11, 64'hC0, 64'hC1);
        expQ.push_back({1'b0, 64'hC0});
        expQ.push_back({1'b1, 64'hC1});
        tick();
        drive(2'b00, 64'h0, 64'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL clear_order got %0d words left required 0", expQ.size());
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        wrapMode = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(2'b11, 64'hF00 + 64'(k), 64'hF80 + 64'(k));
            tick();
        end
        drive(2'b00, 64'h0, 64'h0);
        checks++;
        if ({ovf, level} !== {1'b1, 5'd16}) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got o=%0b lvl=%0d required 1/16", ovf, level);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        expQ.delete();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_ch, level, full, empty, ovf, dropCnt} !==
            {1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL rstmid got v=%0b d=%0h lvl=%0d f=%0b e=%0b o=%0b drop=%0h required all reset",
                     bus.out_valid, bus.out_data, level, full, empty, ovf, dropCnt);
        end
        tick();
        rst = 1'b1;
        tick();
        wrapMode = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear = 1'b0;
        capEn = 1'b1;
        wrapMode = 1'b0;
        bus.ch_valid = '0;
        bus.ch_data = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_stop_full();
        test_wrap_full();
        test_push_pop_full();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
